// File: rtl/trig_pulse_gen.sv
// trig_pulse_gen: one-shot TRIG pulse driver for an ultrasonic ranger.
// Emits a fixed-width pulse, then a holdoff window, then a done strobe.
module trig_pulse_gen #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int PULSE_US   = 10,
  parameter int HOLDOFF_MS = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  output logic o_trig,
  output logic o_busy,
  output logic o_done
);

  localparam int PULSE_CYC = CLK_HZ / 1_000_000 * PULSE_US;
  localparam int HOLD_CYC  = CLK_HZ / 1_000 * HOLDOFF_MS;
  localparam int MAX_CYC   = (PULSE_CYC > HOLD_CYC) ? PULSE_CYC
                                                    : HOLD_CYC;
  localparam int CW        = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYC - 1);

  if (PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_param_chk
    $error("trig_pulse_gen: PULSE_CYC and HOLD_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          trig_d, busy_d, done_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      o_trig <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      o_trig <= trig_d;
      o_busy <= busy_d;
      o_done <= done_d;
    end
  end

  // Outputs are computed one cycle ahead and registered alongside state.
  always_comb begin
    state_d = state;
    cnt_d   = '0;
    trig_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_d = PULSE;
          trig_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      PULSE: begin
        busy_d = 1'b1;
        if (cnt == P_LAST) begin
          state_d = HOLD;
        end else begin
          cnt_d  = cnt + 1'b1;
          trig_d = 1'b1;
        end
      end
      HOLD: begin
        if (cnt == H_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt + 1'b1;
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
